ibex_dummy_instr_burst: RTL and testbench



---
 rtl/ibex_pkg.sv | 29 ++
 rtl/ibex_dummy_instr_lfsr.sv | 50 +++++
 rtl/ibex_dummy_instr_burst.sv | 183 ++++++++++++++++++
 tb/tb_ibex_dummy_instr_burst.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types and constants for the dummy-instruction burst inserter.
//   dummy_state_e           : inserter FSM states
//   RndCnstLfsrSeedDefault  : default LFSR seed (also the zero-lock escape value)
//   RndCnstLfsrPolyDefault  : default Galois feedback taps
//   DUMMY_*_F7 / DUMMY_*_F3 : funct7/funct3 of the four dummy instruction classes
//   OPCODE_OP               : R-type ALU major opcode
package ibex_pkg;

  typedef enum logic {
    DUMMY_IDLE   = 1'b0,
    DUMMY_INSERT = 1'b1
  } dummy_state_e;

  localparam logic [31:0] RndCnstLfsrSeedDefault = 32'hac533bf4;
  localparam logic [31:0] RndCnstLfsrPolyDefault = 32'h80000057;

  localparam logic [6:0] DUMMY_ADD_F7 = 7'b0000000;
  localparam logic [6:0] DUMMY_MUL_F7 = 7'b0000001;
  localparam logic [6:0] DUMMY_DIV_F7 = 7'b0000001;
  localparam logic [6:0] DUMMY_AND_F7 = 7'b0000000;

  localparam logic [2:0] DUMMY_ADD_F3 = 3'b000;
  localparam logic [2:0] DUMMY_MUL_F3 = 3'b000;
  localparam logic [2:0] DUMMY_DIV_F3 = 3'b100;
  localparam logic [2:0] DUMMY_AND_F3 = 3'b111;

  localparam logic [6:0] OPCODE_OP = 7'h33;

endpackage

// File: rtl/ibex_dummy_instr_lfsr.sv
// ibex_dummy_instr_lfsr: Galois LFSR with seed load and zero-lock guard.
//   clk_i, rst_ni : clock, asynchronous active-low reset (loads Seed)
//   seed_en_i     : load seed_i (has priority over en_i)
//   seed_i        : value to load
//   en_i          : advance one step
//   lfsr_d_o      : value lfsr_q_o takes at the next edge
//   lfsr_q_o      : current state
module ibex_dummy_instr_lfsr #(
  parameter int unsigned          LfsrWidth = 32,
  parameter logic [LfsrWidth-1:0] Seed      = '1,
  parameter logic [LfsrWidth-1:0] Poly      = '1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 seed_en_i,
  input  logic [LfsrWidth-1:0] seed_i,
  input  logic                 en_i,
  output logic [LfsrWidth-1:0] lfsr_d_o,
  output logic [LfsrWidth-1:0] lfsr_q_o
);

  logic [LfsrWidth-1:0] lfsr_q, lfsr_d, lfsr_step;

  assign lfsr_step = ({LfsrWidth{lfsr_q[0]}} & Poly) ^ (lfsr_q >> 1);

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_en_i) begin
      lfsr_d = seed_i;
    end else if (en_i) begin
      lfsr_d = lfsr_step;
    end
    // An all-zero state would lock the LFSR forever; escape to the default seed.
    if (lfsr_d == '0) begin
      lfsr_d = Seed;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_d_o = lfsr_d;
  assign lfsr_q_o = lfsr_q;

endmodule

// File: rtl/ibex_dummy_instr_burst.sv
// ibex_dummy_instr_burst: inserts bursts of randomised rd=x0 R-type instructions
// between IF and ID after an LFSR-chosen number of real fetches.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   dummy_instr_en_i       : feature enable (dropping it aborts a burst at once)
//   dummy_instr_mask_i     : upper threshold mask bits
//   burst_len_i            : burst length minus one
//   dummy_instr_seed_en_i  : seed update strobe
//   dummy_instr_seed_i     : seed entropy
//   fetch_valid_i          : real instruction available from IF
//   id_in_ready_i          : ID accepts an instruction this cycle
//   insert_dummy_instr_o   : dummy instruction replaces the fetch output
//   dummy_instr_data_o     : dummy instruction encoding
//   dummy_instr_cnt_o      : inserted-instruction count
// Build option: define IBEX_DUMMY_INSTR_STATS_EN to enable the saturating
// inserted-instruction counter; otherwise dummy_instr_cnt_o is tied to zero.
module ibex_dummy_instr_burst import ibex_pkg::*; #(
  parameter int unsigned          LfsrWidth       = 32,
  parameter int unsigned          CntW            = 5,
  parameter int unsigned          BurstW          = 2,
  parameter logic [LfsrWidth-1:0] RndCnstLfsrSeed = RndCnstLfsrSeedDefault,
  parameter logic [LfsrWidth-1:0] RndCnstLfsrPoly = RndCnstLfsrPolyDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 dummy_instr_en_i,
  input  logic [CntW-3:0]      dummy_instr_mask_i,
  input  logic [BurstW-1:0]    burst_len_i,
  input  logic                 dummy_instr_seed_en_i,
  input  logic [LfsrWidth-1:0] dummy_instr_seed_i,
  input  logic                 fetch_valid_i,
  input  logic                 id_in_ready_i,
  output logic                 insert_dummy_instr_o,
  output logic [31:0]          dummy_instr_data_o,
  output logic [15:0]          dummy_instr_cnt_o
);

  dummy_state_e         state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d, thr_q, thr_d, thr;
  logic [BurstW-1:0]    burst_q, burst_d;
  logic [LfsrWidth-1:0] seed_q, seed_d;
  logic [LfsrWidth-1:0] lfsr_q, lfsr_d;
  logic                 start_burst, advance;
  logic [6:0]           funct7;
  logic [2:0]           funct3;

  assign thr         = thr_q & {dummy_instr_mask_i, 2'b11};
  assign start_burst = (state_q == DUMMY_IDLE) && dummy_instr_en_i && (cnt_q == thr);
  assign advance     = insert_dummy_instr_o && id_in_ready_i;
  assign seed_d      = seed_q ^ dummy_instr_seed_i;

  ibex_dummy_instr_lfsr #(
    .LfsrWidth (LfsrWidth),
    .Seed      (RndCnstLfsrSeed),
    .Poly      (RndCnstLfsrPoly)
  ) u_lfsr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .seed_en_i (dummy_instr_seed_en_i),
    .seed_i    (seed_d),
    .en_i      (advance),
    .lfsr_d_o  (lfsr_d),
    .lfsr_q_o  (lfsr_q)
  );

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DUMMY_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. Leaving INSERT always passes through IDLE, so bursts
  // are separated by at least one real fetch slot even with a zero threshold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DUMMY_IDLE: begin
        if (start_burst) state_d = DUMMY_INSERT;
      end
      DUMMY_INSERT: begin
        if (!dummy_instr_en_i) begin
          state_d = DUMMY_IDLE;
        end else if (id_in_ready_i && (burst_q == '0)) begin
          state_d = DUMMY_IDLE;
        end
      end
      default: state_d = DUMMY_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    insert_dummy_instr_o = 1'b0;
    if (state_q == DUMMY_INSERT) begin
      insert_dummy_instr_o = dummy_instr_en_i;
    end
  end

  // Datapath next values
  always_comb begin
    cnt_d   = cnt_q;
    burst_d = burst_q;
    thr_d   = thr_q;
    case (state_q)
      DUMMY_IDLE: begin
        if (dummy_instr_en_i && fetch_valid_i && id_in_ready_i) begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (start_burst) begin
          burst_d = burst_len_i;
        end
      end
      DUMMY_INSERT: begin
        if (!dummy_instr_en_i) begin
          cnt_d = '0;
        end else if (id_in_ready_i) begin
          if (burst_q == '0) begin
            cnt_d = '0;
            // New threshold comes from the value the LFSR holds after this step.
            thr_d = lfsr_d[CntW-1:0];
          end else begin
            burst_d = burst_q - BurstW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      burst_q <= '0;
      thr_q   <= RndCnstLfsrSeed[CntW-1:0];
      seed_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      thr_q   <= thr_d;
      if (dummy_instr_seed_en_i) begin
        seed_q <= seed_d;
      end
    end
  end

  // Instruction class from the top two LFSR bits
  always_comb begin
    funct7 = DUMMY_ADD_F7;
    funct3 = DUMMY_ADD_F3;
    case (lfsr_q[LfsrWidth-1 -: 2])
      2'b01:   begin funct7 = DUMMY_MUL_F7; funct3 = DUMMY_MUL_F3; end
      2'b10:   begin funct7 = DUMMY_DIV_F7; funct3 = DUMMY_DIV_F3; end
      2'b11:   begin funct7 = DUMMY_AND_F7; funct3 = DUMMY_AND_F3; end
      default: begin funct7 = DUMMY_ADD_F7; funct3 = DUMMY_ADD_F3; end
    endcase
  end

  assign dummy_instr_data_o = {funct7, lfsr_q[CntW+4 -: 5], lfsr_q[CntW+9 -: 5],
                               funct3, 5'b00000, OPCODE_OP};

  // Only part of the LFSR state feeds the encoding and threshold.
  logic unused_lfsr;
  assign unused_lfsr = ^{lfsr_q, lfsr_d};

`ifdef IBEX_DUMMY_INSTR_STATS_EN
  logic [15:0] stat_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_cnt_q <= '0;
    end else if (advance && (stat_cnt_q != 16'hFFFF)) begin
      stat_cnt_q <= stat_cnt_q + 16'd1;
    end
  end

  assign dummy_instr_cnt_o = stat_cnt_q;
`else
  assign dummy_instr_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_ibex_dummy_instr_burst.sv
// tb_ibex_dummy_instr_burst: directed self-checking bench for ibex_dummy_instr_burst.
module tb_ibex_dummy_instr_burst;

  localparam logic [31:0] SEED_C = 32'hac533bf4;
  localparam logic [31:0] POLY_C = 32'h80000057;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        dummy_instr_en_i = 1'b0;
  logic [2:0]  dummy_instr_mask_i = 3'b000;
  logic [1:0]  burst_len_i = 2'b00;
  logic        dummy_instr_seed_en_i = 1'b0;
  logic [31:0] dummy_instr_seed_i = 32'h0;
  logic        fetch_valid_i = 1'b0;
  logic        id_in_ready_i = 1'b0;
  logic        insert_dummy_instr_o;
  logic [31:0] dummy_instr_data_o;
  logic [15:0] dummy_instr_cnt_o;

  always #5 clk_i = ~clk_i;

  ibex_dummy_instr_burst dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .dummy_instr_en_i      (dummy_instr_en_i),
    .dummy_instr_mask_i    (dummy_instr_mask_i),
    .burst_len_i           (burst_len_i),
    .dummy_instr_seed_en_i (dummy_instr_seed_en_i),
    .dummy_instr_seed_i    (dummy_instr_seed_i),
    .fetch_valid_i         (fetch_valid_i),
    .id_in_ready_i         (id_in_ready_i),
    .insert_dummy_instr_o  (insert_dummy_instr_o),
    .dummy_instr_data_o    (dummy_instr_data_o),
    .dummy_instr_cnt_o     (dummy_instr_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: LFSR value, latched threshold, accepted insertions
  logic [31:0] lfsr_m;
  logic [4:0]  thr_m;
  int          ins_m;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? POLY_C : 32'h0);
  endfunction

  function automatic logic [31:0] enc(input logic [31:0] x);
    logic [6:0] f7;
    logic [2:0] f3;
    case (x[31:30])
      2'b00:   begin f7 = 7'd0; f3 = 3'd0; end
      2'b01:   begin f7 = 7'd1; f3 = 3'd0; end
      2'b10:   begin f7 = 7'd1; f3 = 3'd4; end
      default: begin f7 = 7'd0; f3 = 3'd7; end
    endcase
    return {f7, x[9:5], x[14:10], f3, 5'd0, 7'h33};
  endfunction

  function automatic int exp_fetch();
    logic [4:0] t;
    t = thr_m & {dummy_instr_mask_i, 2'b11};
    return int'(t) + 1;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One accepted insertion in the reference; last marks the end of a burst.
  task automatic accept_step(input bit last);
    lfsr_m = lfsr_step(lfsr_m);
    ins_m++;
    if (last) thr_m = lfsr_m[4:0];
  endtask

  // Count accepted fetch cycles until an insertion appears (bounded).
  task automatic wait_ins(input string tag, output int n);
    n = 0;
    while (!insert_dummy_instr_o && n < 200) begin
      n++;
      tick();
    end
    if (!insert_dummy_instr_o) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    bit [5:0] stall_pat;

    // Reset state
    tick(); tick();
    check_eq("rst_insert", 64'(insert_dummy_instr_o), 64'd0);
    check_eq("rst_data", 64'(dummy_instr_data_o), 64'h03F74033);
    check_eq("rst_cnt", 64'(dummy_instr_cnt_o), 64'd0);
    $display("[TB] reset: data=%h", dummy_instr_data_o);

    rst_ni = 1'b1;
    lfsr_m = SEED_C;
    thr_m  = SEED_C[4:0];
    ins_m  = 0;
    dummy_instr_en_i = 1'b1;
    fetch_valid_i    = 1'b1;
    id_in_ready_i    = 1'b1;
    #1;

    // Single-cycle insertions, mask=0
    for (int b = 0; b < 4; b++) begin
      wait_ins("t1", n);
      check_eq("t1_fetches", 64'(n), 64'(exp_fetch()));
      check_eq("t1_rd", 64'(dummy_instr_data_o[11:7]), 64'd0);
      check_eq("t1_opcode", 64'(dummy_instr_data_o[6:0]), 64'h33);
      check_eq("t1_data", 64'(dummy_instr_data_o), 64'(enc(lfsr_m)));
      $display("[TB] single burst %0d: fetches=%0d data=%h", b, n, dummy_instr_data_o);
      accept_step(1'b1);
      tick();
      check_eq("t1_single", 64'(insert_dummy_instr_o), 64'd0);
    end

    // Four-instruction burst
    burst_len_i = 2'd3;
    wait_ins("t2", n);
    check_eq("t2_fetches", 64'(n), 64'(exp_fetch()));
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_insert", 64'(insert_dummy_instr_o), 64'd1);
      check_eq("t2_data", 64'(dummy_instr_data_o), 64'(enc(lfsr_m)));
      $display("[TB] burst4 slot %0d: data=%h", i, dummy_instr_data_o);
      accept_step(i == 3);
      tick();
    end
    check_eq("t2_end", 64'(insert_dummy_instr_o), 64'd0);

    // Burst with two stalled cycles: six insert cycles
    wait_ins("t2s", n);
    check_eq("t2s_fetches", 64'(n), 64'(exp_fetch()));
    stall_pat = 6'b111001;  // bit i = ready in slot i
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      id_in_ready_i = stall_pat[i];
      #1;
      check_eq("t2s_insert", 64'(insert_dummy_instr_o), 64'd1);
      check_eq("t2s_data", 64'(dummy_instr_data_o), 64'(enc(lfsr_m)));
      $display("[TB] stall slot %0d: ready=%0d data=%h", i, id_in_ready_i, dummy_instr_data_o);
      if (stall_pat[i]) begin
        acc++;
        accept_step(acc == 4);
      end
      tick();
    end
    id_in_ready_i = 1'b1;
    #1;
    check_eq("t2s_end", 64'(insert_dummy_instr_o), 64'd0);

    // Abort on the second cycle of a burst
    wait_ins("t3", n);
    check_eq("t3_fetches", 64'(n), 64'(exp_fetch()));
    accept_step(1'b0);
    tick();
    dummy_instr_en_i = 1'b0;
    #1;
    check_eq("abort_same", 64'(insert_dummy_instr_o), 64'd0);
    check_eq("abort_data", 64'(dummy_instr_data_o), 64'(enc(lfsr_m)));
    tick();
    dummy_instr_en_i = 1'b1;
    #1;
    check_eq("abort_idle", 64'(insert_dummy_instr_o), 64'd0);
    check_eq("abort_lfsr", 64'(dummy_instr_data_o), 64'(enc(lfsr_m)));
    wait_ins("t3b", n);
    check_eq("abort_cnt", 64'(n), 64'(exp_fetch()));
    $display("[TB] abort: refetch count=%0d", n);
    dummy_instr_en_i = 1'b0;
    #1;
    check_eq("abort2_same", 64'(insert_dummy_instr_o), 64'd0);
    tick(); tick();

    // Zero seed falls back to the default seed
    dummy_instr_seed_en_i = 1'b1;
    dummy_instr_seed_i    = 32'h0;
    tick();
    dummy_instr_seed_en_i = 1'b0;
    lfsr_m = SEED_C;
    check_eq("seed_zero", 64'(dummy_instr_data_o), 64'h03F74033);
    $display("[TB] seed zero: data=%h", dummy_instr_data_o);

    // Seed wins over an accepted insertion in the same cycle
    dummy_instr_en_i = 1'b1;
    burst_len_i = 2'd3;
    wait_ins("t4", n);
    check_eq("seed_keeps_thr", 64'(n), 64'(exp_fetch()));
    check_eq("seed_pre", 64'(dummy_instr_data_o), 64'h03F74033);
    dummy_instr_seed_en_i = 1'b1;
    dummy_instr_seed_i    = 32'h1;
    tick();
    dummy_instr_seed_en_i = 1'b0;
    dummy_instr_seed_i    = 32'h0;
    ins_m++;
    lfsr_m = 32'h1;
    check_eq("seed_wins", 64'(dummy_instr_data_o), 64'h00000033);
    $display("[TB] seed one: data=%h", dummy_instr_data_o);
    accept_step(1'b0);
    tick();
    check_eq("seed_b2", 64'(dummy_instr_data_o), 64'h02204033);
    accept_step(1'b0);
    tick();
    check_eq("seed_b3", 64'(dummy_instr_data_o), 64'h00307033);
    accept_step(1'b1);
    tick();
    check_eq("seed_end", 64'(insert_dummy_instr_o), 64'd0);
    check_eq("seed_thr", 64'(thr_m), 64'd30);

    // Counter wrap with the threshold out of reach, then hit after the wrap
    dummy_instr_mask_i = 3'b111;
    burst_len_i = 2'd0;
    n = 0;
    while (!insert_dummy_instr_o && n < 200) begin
      if (n == 21) dummy_instr_mask_i = 3'b011;
      n++;
      tick();
    end
    check_eq("wrap_fetches", 64'(n), 64'd47);
    check_eq("wrap_data", 64'(dummy_instr_data_o), 64'h02100033);
    $display("[TB] wrap: fetches=%0d data=%h", n, dummy_instr_data_o);
    accept_step(1'b1);
    tick();
    check_eq("wrap_end", 64'(insert_dummy_instr_o), 64'd0);

`ifdef IBEX_DUMMY_INSTR_STATS_EN
    check_eq("stat_cnt", 64'(dummy_instr_cnt_o), 64'(ins_m));
    force dut.stat_cnt_q = 16'hFFFD;
    #1;
    release dut.stat_cnt_q;
    dummy_instr_mask_i = 3'b000;
    burst_len_i = 2'd2;
    wait_ins("t5", n);
    for (int i = 0; i < 3; i++) tick();
    check_eq("stat_sat", 64'(dummy_instr_cnt_o), 64'hFFFF);
    $display("[TB] stats saturate: cnt=%h", dummy_instr_cnt_o);
`else
    check_eq("stat_tied", 64'(dummy_instr_cnt_o), 64'd0);
    $display("[TB] stats disabled: cnt=%h", dummy_instr_cnt_o);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
